// File: rtl/decode_pkg.sv
// Shared constants for the RV64IM decode stage: major opcodes, the "no register"
// source index, operand-format encoding and the ASCII mnemonic table.
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [5:0] NO_REG = 6'h20;

    // Operand layout selects which fields feed rd / source indices / immediate
    typedef enum logic [3:0] {
        FMT_ILL, FMT_R, FMT_I, FMT_SH6, FMT_SH5, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS
    } fmt_t;

    typedef struct packed {
        logic [63:0] mnem;
        logic [5:0]  rd;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [19:0] imm;
    } dec_t;

    // Mnemonics: lowercase ASCII, right-justified, zero-padded high bytes
    localparam logic [63:0] M_LUI     = {40'h0, "lui"};
    localparam logic [63:0] M_AUIPC   = {24'h0, "auipc"};
    localparam logic [63:0] M_JAL     = {40'h0, "jal"};
    localparam logic [63:0] M_JALR    = {32'h0, "jalr"};
    localparam logic [63:0] M_BEQ     = {40'h0, "beq"};
    localparam logic [63:0] M_BNE     = {40'h0, "bne"};
    localparam logic [63:0] M_BLT     = {40'h0, "blt"};
    localparam logic [63:0] M_BGE     = {40'h0, "bge"};
    localparam logic [63:0] M_BLTU    = {32'h0, "bltu"};
    localparam logic [63:0] M_BGEU    = {32'h0, "bgeu"};
    localparam logic [63:0] M_LB      = {48'h0, "lb"};
    localparam logic [63:0] M_LH      = {48'h0, "lh"};
    localparam logic [63:0] M_LW      = {48'h0, "lw"};
    localparam logic [63:0] M_LD      = {48'h0, "ld"};
    localparam logic [63:0] M_LBU     = {40'h0, "lbu"};
    localparam logic [63:0] M_LHU     = {40'h0, "lhu"};
    localparam logic [63:0] M_LWU     = {40'h0, "lwu"};
    localparam logic [63:0] M_SB      = {48'h0, "sb"};
    localparam logic [63:0] M_SH      = {48'h0, "sh"};
    localparam logic [63:0] M_SW      = {48'h0, "sw"};
    localparam logic [63:0] M_SD      = {48'h0, "sd"};
    localparam logic [63:0] M_ADDI    = {32'h0, "addi"};
    localparam logic [63:0] M_SLTI    = {32'h0, "slti"};
    localparam logic [63:0] M_SLTIU   = {24'h0, "sltiu"};
    localparam logic [63:0] M_XORI    = {32'h0, "xori"};
    localparam logic [63:0] M_ORI     = {40'h0, "ori"};
    localparam logic [63:0] M_ANDI    = {32'h0, "andi"};
    localparam logic [63:0] M_SLLI    = {32'h0, "slli"};
    localparam logic [63:0] M_SRLI    = {32'h0, "srli"};
    localparam logic [63:0] M_SRAI    = {32'h0, "srai"};
    localparam logic [63:0] M_ADDIW   = {24'h0, "addiw"};
    localparam logic [63:0] M_SLLIW   = {24'h0, "slliw"};
    localparam logic [63:0] M_SRLIW   = {24'h0, "srliw"};
    localparam logic [63:0] M_SRAIW   = {24'h0, "sraiw"};
    localparam logic [63:0] M_ADD     = {40'h0, "add"};
    localparam logic [63:0] M_SUB     = {40'h0, "sub"};
    localparam logic [63:0] M_SLL     = {40'h0, "sll"};
    localparam logic [63:0] M_SLT     = {40'h0, "slt"};
    localparam logic [63:0] M_SLTU    = {32'h0, "sltu"};
    localparam logic [63:0] M_XOR     = {40'h0, "xor"};
    localparam logic [63:0] M_SRL     = {40'h0, "srl"};
    localparam logic [63:0] M_SRA     = {40'h0, "sra"};
    localparam logic [63:0] M_OR      = {48'h0, "or"};
    localparam logic [63:0] M_AND     = {40'h0, "and"};
    localparam logic [63:0] M_ADDW    = {32'h0, "addw"};
    localparam logic [63:0] M_SUBW    = {32'h0, "subw"};
    localparam logic [63:0] M_SLLW    = {32'h0, "sllw"};
    localparam logic [63:0] M_SRLW    = {32'h0, "srlw"};
    localparam logic [63:0] M_SRAW    = {32'h0, "sraw"};
    localparam logic [63:0] M_MUL     = {40'h0, "mul"};
    localparam logic [63:0] M_MULH    = {32'h0, "mulh"};
    localparam logic [63:0] M_MULHSU  = {16'h0, "mulhsu"};
    localparam logic [63:0] M_MULHU   = {24'h0, "mulhu"};
    localparam logic [63:0] M_DIV     = {40'h0, "div"};
    localparam logic [63:0] M_DIVU    = {32'h0, "divu"};
    localparam logic [63:0] M_REM     = {40'h0, "rem"};
    localparam logic [63:0] M_REMU    = {32'h0, "remu"};
    localparam logic [63:0] M_MULW    = {32'h0, "mulw"};
    localparam logic [63:0] M_DIVW    = {32'h0, "divw"};
    localparam logic [63:0] M_DIVUW   = {24'h0, "divuw"};
    localparam logic [63:0] M_REMW    = {32'h0, "remw"};
    localparam logic [63:0] M_REMUW   = {24'h0, "remuw"};
    localparam logic [63:0] M_FENCE   = {24'h0, "fence"};
    localparam logic [63:0] M_ECALL   = {24'h0, "ecall"};
    localparam logic [63:0] M_EBREAK  = {16'h0, "ebreak"};
    localparam logic [63:0] M_ILLEGAL = {8'h0, "illegal"};

endpackage

// File: rtl/decode_regfile.sv
// 32x64 integer register file: two asynchronous read ports with write-to-read
// bypass, one synchronous write port, x0 hardwired to zero.
module decode_regfile
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wen,
    input  logic [5:0]  wr_idx,
    input  logic [63:0] wr_data,
    input  logic [5:0]  rd_idx_a,
    input  logic [5:0]  rd_idx_b,
    output logic [63:0] rd_data_a,
    output logic [63:0] rd_data_b
);

    logic [63:0] mem [32];
    logic        wr_ok;

    // Indices 0 and >=32 never write; the >=32 check also keeps NO_REG sources
    // from picking up a bypass
    assign wr_ok = wen && !wr_idx[5] && (wr_idx[4:0] != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_idx[4:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = '0;
        if (!rd_idx_a[5] && rd_idx_a[4:0] != 5'd0) begin
            rd_data_a = (wr_ok && wr_idx == rd_idx_a) ? wr_data : mem[rd_idx_a[4:0]];
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (!rd_idx_b[5] && rd_idx_b[4:0] != 5'd0) begin
            rd_data_b = (wr_ok && wr_idx == rd_idx_b) ? wr_data : mem[rd_idx_b[4:0]];
        end
    end

endmodule

// File: rtl/decode_mod.sv
// RV64IM decode stage: combinational decode and register read feeding a single
// output register bank, with stall hold and branch flush.
module decode_mod
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IFID_instreg,
    input  logic [63:0] IFID_npc,
    input  logic        IFID_ready,
    input  logic        EXID_stall,
    input  logic        EXIF_branch,
    input  logic        WBID_wen,
    input  logic [5:0]  WBID_rd,
    input  logic [63:0] WBID_rdval,
    output logic        IDEX_ready,
    output logic [63:0] IDEX_npc,
    output logic [63:0] opcode,
    output logic [63:0] rs1,
    output logic [63:0] rs2,
    output logic [5:0]  rd,
    output logic [19:0] immediate,
    output logic [5:0]  IDEX_rs1reg,
    output logic [5:0]  IDEX_rs2reg,
    output logic        IDIF_stall
);

    logic [31:0] inst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] mnem;
    fmt_t        fmt;
    logic        bad;
    dec_t        dec;
    logic [63:0] val_a;
    logic [63:0] val_b;

    assign inst = IFID_instreg;
    assign opc  = inst[6:0];
    assign f3   = inst[14:12];
    assign f7   = inst[31:25];

    assign IDIF_stall = EXID_stall;

    // Each major opcode picks a format, the inner case picks the mnemonic; any
    // unmatched sub-encoding falls back to illegal in one place at the end
    always_comb begin
        mnem = M_ILLEGAL;
        fmt  = FMT_ILL;
        bad  = 1'b0;
        case (opc)
            OP_LUI:   begin fmt = FMT_U; mnem = M_LUI;   end
            OP_AUIPC: begin fmt = FMT_U; mnem = M_AUIPC; end
            OP_JAL:   begin fmt = FMT_J; mnem = M_JAL;   end
            OP_JALR: begin
                fmt  = FMT_I;
                mnem = M_JALR;
                bad  = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                case (f3)
                    3'b000:  mnem = M_BEQ;
                    3'b001:  mnem = M_BNE;
                    3'b100:  mnem = M_BLT;
                    3'b101:  mnem = M_BGE;
                    3'b110:  mnem = M_BLTU;
                    3'b111:  mnem = M_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                fmt = FMT_I;
                case (f3)
                    3'b000:  mnem = M_LB;
                    3'b001:  mnem = M_LH;
                    3'b010:  mnem = M_LW;
                    3'b011:  mnem = M_LD;
                    3'b100:  mnem = M_LBU;
                    3'b101:  mnem = M_LHU;
                    3'b110:  mnem = M_LWU;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                fmt = FMT_S;
                case (f3)
                    3'b000:  mnem = M_SB;
                    3'b001:  mnem = M_SH;
                    3'b010:  mnem = M_SW;
                    3'b011:  mnem = M_SD;
                    default: bad = 1'b1;
                endcase
            end
            OP_IMM: begin
                fmt = FMT_I;
                case (f3)
                    3'b000: mnem = M_ADDI;
                    3'b010: mnem = M_SLTI;
                    3'b011: mnem = M_SLTIU;
                    3'b100: mnem = M_XORI;
                    3'b110: mnem = M_ORI;
                    3'b111: mnem = M_ANDI;
                    3'b001: begin
                        fmt = FMT_SH6;
                        if (inst[31:26] == 6'b000000) mnem = M_SLLI;
                        else                          bad = 1'b1;
                    end
                    default: begin
                        fmt = FMT_SH6;
                        if (inst[31:26] == 6'b000000)      mnem = M_SRLI;
                        else if (inst[31:26] == 6'b010000) mnem = M_SRAI;
                        else                               bad = 1'b1;
                    end
                endcase
            end
            OP_IMM32: begin
                fmt = FMT_SH5;
                case (f3)
                    3'b000: begin fmt = FMT_I; mnem = M_ADDIW; end
                    3'b001: begin
                        if (f7 == 7'b0000000) mnem = M_SLLIW;
                        else                  bad = 1'b1;
                    end
                    3'b101: begin
                        if (f7 == 7'b0000000)      mnem = M_SRLIW;
                        else if (f7 == 7'b0100000) mnem = M_SRAIW;
                        else                       bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_REG: begin
                fmt = FMT_R;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  mnem = M_ADD;
                            3'b001:  mnem = M_SLL;
                            3'b010:  mnem = M_SLT;
                            3'b011:  mnem = M_SLTU;
                            3'b100:  mnem = M_XOR;
                            3'b101:  mnem = M_SRL;
                            3'b110:  mnem = M_OR;
                            default: mnem = M_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (f3)
                            3'b000:  mnem = M_SUB;
                            3'b101:  mnem = M_SRA;
                            default: bad = 1'b1;
                        endcase
                    end
                    7'b0000001: begin
                        case (f3)
                            3'b000:  mnem = M_MUL;
                            3'b001:  mnem = M_MULH;
                            3'b010:  mnem = M_MULHSU;
                            3'b011:  mnem = M_MULHU;
                            3'b100:  mnem = M_DIV;
                            3'b101:  mnem = M_DIVU;
                            3'b110:  mnem = M_REM;
                            default: mnem = M_REMU;
                        endcase
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_REG32: begin
                fmt = FMT_R;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  mnem = M_ADDW;
                            3'b001:  mnem = M_SLLW;
                            3'b101:  mnem = M_SRLW;
                            default: bad = 1'b1;
                        endcase
                    end
                    7'b0100000: begin
                        case (f3)
                            3'b000:  mnem = M_SUBW;
                            3'b101:  mnem = M_SRAW;
                            default: bad = 1'b1;
                        endcase
                    end
                    7'b0000001: begin
                        case (f3)
                            3'b000:  mnem = M_MULW;
                            3'b100:  mnem = M_DIVW;
                            3'b101:  mnem = M_DIVUW;
                            3'b110:  mnem = M_REMW;
                            3'b111:  mnem = M_REMUW;
                            default: bad = 1'b1;
                        endcase
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_FENCE: begin
                fmt  = FMT_SYS;
                mnem = M_FENCE;
                bad  = (f3 != 3'b000);
            end
            OP_SYSTEM: begin
                fmt = FMT_SYS;
                if (inst[31:7] == 25'd0)                 mnem = M_ECALL;
                else if (inst[31:7] == {12'h001, 13'd0}) mnem = M_EBREAK;
                else                                     bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            mnem = M_ILLEGAL;
            fmt  = FMT_ILL;
        end
    end

    always_comb begin
        dec.mnem = mnem;
        dec.rd   = '0;
        dec.rs1  = NO_REG;
        dec.rs2  = NO_REG;
        dec.imm  = '0;
        case (fmt)
            FMT_R: begin
                dec.rd  = {1'b0, inst[11:7]};
                dec.rs1 = {1'b0, inst[19:15]};
                dec.rs2 = {1'b0, inst[24:20]};
            end
            FMT_I: begin
                dec.rd  = {1'b0, inst[11:7]};
                dec.rs1 = {1'b0, inst[19:15]};
                dec.imm = {{8{inst[31]}}, inst[31:20]};
            end
            FMT_SH6: begin
                dec.rd  = {1'b0, inst[11:7]};
                dec.rs1 = {1'b0, inst[19:15]};
                dec.imm = {14'd0, inst[25:20]};
            end
            FMT_SH5: begin
                dec.rd  = {1'b0, inst[11:7]};
                dec.rs1 = {1'b0, inst[19:15]};
                dec.imm = {15'd0, inst[24:20]};
            end
            FMT_S: begin
                dec.rs1 = {1'b0, inst[19:15]};
                dec.rs2 = {1'b0, inst[24:20]};
                dec.imm = {{8{inst[31]}}, inst[31:25], inst[11:7]};
            end
            FMT_B: begin
                dec.rs1 = {1'b0, inst[19:15]};
                dec.rs2 = {1'b0, inst[24:20]};
                dec.imm = {{7{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            FMT_U: begin
                dec.rd  = {1'b0, inst[11:7]};
                dec.imm = inst[31:12];
            end
            FMT_J: begin
                dec.rd  = {1'b0, inst[11:7]};
                dec.imm = {inst[31], inst[19:12], inst[20], inst[30:21]};
            end
            FMT_SYS: begin
                dec.imm = {{8{inst[31]}}, inst[31:20]};
            end
            default: ;
        endcase
    end

    decode_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .wen       (WBID_wen),
        .wr_idx    (WBID_rd),
        .wr_data   (WBID_rdval),
        .rd_idx_a  (dec.rs1),
        .rd_idx_b  (dec.rs2),
        .rd_data_a (val_a),
        .rd_data_b (val_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            IDEX_ready  <= 1'b0;
            IDEX_npc    <= '0;
            opcode      <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            immediate   <= '0;
            IDEX_rs1reg <= NO_REG;
            IDEX_rs2reg <= NO_REG;
        end else if (EXIF_branch) begin
            IDEX_ready <= 1'b0;
            opcode     <= '0;
        end else if (EXID_stall) begin
            IDEX_ready <= IDEX_ready;
        end else if (IFID_ready) begin
            IDEX_ready  <= 1'b1;
            IDEX_npc    <= IFID_npc;
            opcode      <= dec.mnem;
            rs1         <= val_a;
            rs2         <= val_b;
            rd          <= dec.rd;
            immediate   <= dec.imm;
            IDEX_rs1reg <= dec.rs1;
            IDEX_rs2reg <= dec.rs2;
        end else begin
            IDEX_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_mod.sv
// Directed bench for decode_mod: table of hand-encoded instructions plus
// sequences for bypass, stall hold, flush and mid-stream reset.
module tb_decode_mod;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IFID_instreg;
    logic [63:0] IFID_npc;
    logic        IFID_ready;
    logic        EXID_stall;
    logic        EXIF_branch;
    logic        WBID_wen;
    logic [5:0]  WBID_rd;
    logic [63:0] WBID_rdval;
    logic        IDEX_ready;
    logic [63:0] IDEX_npc;
    logic [63:0] opcode;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [5:0]  rd;
    logic [19:0] immediate;
    logic [5:0]  IDEX_rs1reg;
    logic [5:0]  IDEX_rs2reg;
    logic        IDIF_stall;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] A_ADDI = 64'h0000_0000_6164_6469;
    localparam logic [63:0] A_ADD  = 64'h0000_0000_0061_6464;
    localparam logic [63:0] A_LUI  = 64'h0000_0000_006c_7569;
    localparam logic [63:0] A_ILL  = 64'h0069_6c6c_6567_616c;

    decode_mod dut (
        .clk          (clk),
        .reset        (reset),
        .IFID_instreg (IFID_instreg),
        .IFID_npc     (IFID_npc),
        .IFID_ready   (IFID_ready),
        .EXID_stall   (EXID_stall),
        .EXIF_branch  (EXIF_branch),
        .WBID_wen     (WBID_wen),
        .WBID_rd      (WBID_rd),
        .WBID_rdval   (WBID_rdval),
        .IDEX_ready   (IDEX_ready),
        .IDEX_npc     (IDEX_npc),
        .opcode       (opcode),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .immediate    (immediate),
        .IDEX_rs1reg  (IDEX_rs1reg),
        .IDEX_rs2reg  (IDEX_rs2reg),
        .IDIF_stall   (IDIF_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] inst;
        logic [63:0] op;
        logic [5:0]  rdi;
        logic [5:0]  s1;
        logic [5:0]  s2;
        logic [19:0] imm;
        logic [63:0] v1;
        logic [63:0] v2;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00293, A_ADDI,                 6'd5, 6'd0,  6'h20, 20'hFFFFF, 64'h0,    64'h0};
        vecs[1]  = '{32'h123450B7, A_LUI,                  6'd1, 6'h20, 6'h20, 20'h12345, 64'h0,    64'h0};
        vecs[2]  = '{32'hFE208CE3, 64'h0000_0000_0062_6571, 6'd0, 6'd1,  6'd2,  20'hFFFF8, 64'h1111, 64'h2222};
        vecs[3]  = '{32'h002081B3, A_ADD,                  6'd3, 6'd1,  6'd2,  20'h00000, 64'h1111, 64'h2222};
        vecs[4]  = '{32'h402081B3, 64'h0000_0000_0073_7562, 6'd3, 6'd1,  6'd2,  20'h00000, 64'h1111, 64'h2222};
        vecs[5]  = '{32'h03F09213, 64'h0000_0000_736c_6c69, 6'd4, 6'd1,  6'h20, 20'h0003F, 64'h1111, 64'h0};
        vecs[6]  = '{32'h4050D213, 64'h0000_0000_7372_6169, 6'd4, 6'd1,  6'h20, 20'h00005, 64'h1111, 64'h0};
        vecs[7]  = '{32'hFE20AE23, 64'h0000_0000_0000_7377, 6'd0, 6'd1,  6'd2,  20'hFFFFC, 64'h1111, 64'h2222};
        vecs[8]  = '{32'h008000EF, 64'h0000_0000_006a_616c, 6'd1, 6'h20, 6'h20, 20'h00004, 64'h0,    64'h0};
        vecs[9]  = '{32'h022083BB, 64'h0000_0000_6d75_6c77, 6'd7, 6'd1,  6'd2,  20'h00000, 64'h1111, 64'h2222};
        vecs[10] = '{32'hFFFFFFFF, A_ILL,                  6'd0, 6'h20, 6'h20, 20'h00000, 64'h0,    64'h0};
        vecs[11] = '{32'h01013403, 64'h0000_0000_0000_6c64, 6'd8, 6'd2,  6'h20, 20'h00010, 64'h2222, 64'h0};
        vecs[12] = '{32'h00000073, 64'h0000_0065_6361_6c6c, 6'd0, 6'h20, 6'h20, 20'h00000, 64'h0,    64'h0};
        vecs[13] = '{32'h01F0D21B, 64'h0000_0073_726c_6977, 6'd4, 6'd1,  6'h20, 20'h0001F, 64'h1111, 64'h0};
        vecs[14] = '{32'h00000000, A_ILL,                  6'd0, 6'h20, 6'h20, 20'h00000, 64'h0,    64'h0};
        vecs[15] = '{32'h04009213, A_ILL,                  6'd0, 6'h20, 6'h20, 20'h00000, 64'h0,    64'h0};

        reset = 1'b1; IFID_instreg = '0; IFID_npc = '0; IFID_ready = 1'b0;
        EXID_stall = 1'b1; EXIF_branch = 1'b0;
        WBID_wen = 1'b0; WBID_rd = '0; WBID_rdval = '0;
        #1;
        tick(); tick();
        check("reset_idif_stall_hi", 64'(IDIF_stall), 64'd1);
        check("reset_ready", 64'(IDEX_ready), 64'd0);
        check("reset_npc", IDEX_npc, 64'd0);
        check("reset_opcode", opcode, 64'd0);
        check("reset_rs1", rs1, 64'd0);
        check("reset_rs2", rs2, 64'd0);
        check("reset_rd", 64'(rd), 64'd0);
        check("reset_imm", 64'(immediate), 64'd0);
        check("reset_rs1reg", 64'(IDEX_rs1reg), 64'h20);
        check("reset_rs2reg", 64'(IDEX_rs2reg), 64'h20);
        EXID_stall = 1'b0;
        #1;
        check("reset_idif_stall_lo", 64'(IDIF_stall), 64'd0);
        reset = 1'b0;

        WBID_wen = 1'b1; WBID_rd = 6'd1; WBID_rdval = 64'h1111;
        tick();
        WBID_rd = 6'd2; WBID_rdval = 64'h2222;
        tick();
        WBID_wen = 1'b0;
        check("idle_not_ready", 64'(IDEX_ready), 64'd0);

        for (int i = 0; i < 16; i++) begin
            IFID_instreg = vecs[i].inst;
            IFID_npc     = 64'h1000 + 64'(i * 4);
            IFID_ready   = 1'b1;
            tick();
            check($sformatf("v%0d_ready", i), 64'(IDEX_ready), 64'd1);
            check($sformatf("v%0d_npc", i), IDEX_npc, 64'h1000 + 64'(i * 4));
            check($sformatf("v%0d_opcode", i), opcode, vecs[i].op);
            check($sformatf("v%0d_rd", i), 64'(rd), 64'(vecs[i].rdi));
            check($sformatf("v%0d_rs1reg", i), 64'(IDEX_rs1reg), 64'(vecs[i].s1));
            check($sformatf("v%0d_rs2reg", i), 64'(IDEX_rs2reg), 64'(vecs[i].s2));
            check($sformatf("v%0d_imm", i), 64'(immediate), 64'(vecs[i].imm));
            check($sformatf("v%0d_rs1", i), rs1, vecs[i].v1);
            check($sformatf("v%0d_rs2", i), rs2, vecs[i].v2);
        end
        IFID_ready = 1'b0;
        tick();
        check("bubble_ready", 64'(IDEX_ready), 64'd0);

        // same-cycle writeback bypass, then a plain read of the written register
        IFID_ready = 1'b1; IFID_instreg = 32'h00528333; IFID_npc = 64'h1100;
        WBID_wen = 1'b1; WBID_rd = 6'd5; WBID_rdval = 64'hDEAD;
        tick();
        check("byp_opcode", opcode, A_ADD);
        check("byp_rd", 64'(rd), 64'd6);
        check("byp_rs1", rs1, 64'hDEAD);
        check("byp_rs2", rs2, 64'hDEAD);
        WBID_wen = 1'b0; IFID_instreg = 32'h00028493;
        tick();
        check("rdback_opcode", opcode, A_ADDI);
        check("rdback_rd", 64'(rd), 64'd9);
        check("rdback_rs1", rs1, 64'hDEAD);

        // writes to x0 and to index 32 are ignored, and never bypass
        IFID_instreg = 32'h00000013; WBID_wen = 1'b1; WBID_rd = 6'd0; WBID_rdval = 64'hFFFF;
        tick();
        check("x0_bypass", rs1, 64'd0);
        IFID_instreg = 32'h123450B7; WBID_rd = 6'h20; WBID_rdval = 64'hBAD;
        tick();
        check("noreg_rs1", rs1, 64'd0);
        check("noreg_rs2", rs2, 64'd0);
        WBID_wen = 1'b0; IFID_instreg = 32'h00000013;
        tick();
        check("x0_after_write", rs1, 64'd0);

        // stall hold for three cycles, with a register write landing meanwhile
        IFID_instreg = 32'h002081B3; IFID_npc = 64'h2000;
        tick();
        EXID_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            IFID_instreg = (k == 1) ? 32'hFFFFFFFF : 32'h123450B7;
            IFID_npc = 64'h3000 + 64'(k);
            WBID_wen = (k == 0); WBID_rd = 6'd10; WBID_rdval = 64'h77;
            #1;
            check($sformatf("stall%0d_idif", k), 64'(IDIF_stall), 64'd1);
            tick();
            check($sformatf("stall%0d_opcode", k), opcode, A_ADD);
            check($sformatf("stall%0d_npc", k), IDEX_npc, 64'h2000);
            check($sformatf("stall%0d_ready", k), 64'(IDEX_ready), 64'd1);
            check($sformatf("stall%0d_rd", k), 64'(rd), 64'd3);
        end
        EXID_stall = 1'b0; WBID_wen = 1'b0;
        #1;
        check("unstall_idif", 64'(IDIF_stall), 64'd0);

        EXIF_branch = 1'b1;
        tick();
        check("flush_ready", 64'(IDEX_ready), 64'd0);
        check("flush_opcode", opcode, 64'd0);
        EXIF_branch = 1'b0; IFID_instreg = 32'h00050593; IFID_npc = 64'h4000;
        tick();
        check("post_flush_ready", 64'(IDEX_ready), 64'd1);
        check("post_flush_opcode", opcode, A_ADDI);
        check("stall_write_rs1", rs1, 64'h77);
        check("post_flush_rd", 64'(rd), 64'd11);

        EXIF_branch = 1'b1; EXID_stall = 1'b1;
        tick();
        check("branch_over_stall_ready", 64'(IDEX_ready), 64'd0);
        check("branch_over_stall_op", opcode, 64'd0);
        EXIF_branch = 1'b0; EXID_stall = 1'b0;

        // reset mid-stream drops the in-flight word and clears the register file
        IFID_instreg = 32'h002081B3; IFID_npc = 64'h5000; reset = 1'b1;
        tick();
        check("midrst_ready", 64'(IDEX_ready), 64'd0);
        check("midrst_opcode", opcode, 64'd0);
        check("midrst_npc", IDEX_npc, 64'd0);
        check("midrst_rs1reg", 64'(IDEX_rs1reg), 64'h20);
        reset = 1'b0; IFID_ready = 1'b0;
        tick();
        check("midrst_idle", 64'(IDEX_ready), 64'd0);
        IFID_ready = 1'b1;
        tick();
        check("midrst_first_ready", 64'(IDEX_ready), 64'd1);
        check("midrst_first_npc", IDEX_npc, 64'h5000);
        check("midrst_regs_rs1", rs1, 64'd0);
        check("midrst_regs_rs2", rs2, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_mod.md
DECODE_MOD -- requirements
Module: decode_mod

Interface
REQ-001 Parameters: none; data width fixed at 64 bits (RV64).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 IFID_instreg  in  32  fetched instruction word.
REQ-005 IFID_npc  in  64  PC of the fetched instruction.
REQ-006 IFID_ready  in  1  IFID_instreg/IFID_npc valid this cycle.
REQ-007 EXID_stall  in  1  execute cannot accept; hold outputs.
REQ-008 EXIF_branch  in  1  taken branch/jump resolved in execute; flush.
REQ-009 WBID_wen  in  1  register-file write enable from writeback.
REQ-010 WBID_rd  in  6  write index; 0 or >=32 ignored.
REQ-011 WBID_rdval  in  64  write data.
REQ-012 IDEX_ready  out  1  registered outputs hold a valid decoded instruction.
REQ-013 IDEX_npc  out  64  registered copy of IFID_npc.
REQ-014 opcode  out  64  mnemonic, lowercase ASCII, right-justified, zero-padded high bytes ("addi" = 64'h0000_0000_6164_6469).
REQ-015 rs1, rs2  out  64 each  source register values.
REQ-016 rd  out  6  destination index; 0 when none.
REQ-017 immediate  out  20  decoded immediate.
REQ-018 IDEX_rs1reg, IDEX_rs2reg  out  6 each  source indices; 6'h20 when unused.
REQ-019 IDIF_stall  out  1  freeze fetch.

Function
REQ-020 Decode full RV64IM: lui auipc jal jalr, beq bne blt bge bltu bgeu, lb lh lw ld lbu lhu lwu, sb sh sw sd, addi slti sltiu xori ori andi slli srli srai, addiw slliw srliw sraiw, add sub sll slt sltu xor srl sra or and, addw subw sllw srlw sraw, mul mulh mulhsu mulhu div divu rem remu, mulw divw divuw remw remuw, fence ecall ebreak; any other encoding -> "illegal", rd 0, both src indices 6'h20.
REQ-021 Immediate: I/S/B types sign-extended to 20 bits (B includes bit 0 = 0); U type inst[31:12]; JAL imm[20:1]; shift-immediates zero-extended shamt (6 bits RV64, 5 bits W forms).
REQ-022 rs1/rs2 values read from internal 32x64 register file; x0 reads 0; unused source value 0.
REQ-023 Write-to-read bypass: WBID_wen with WBID_rd equal to a source index in the same cycle yields WBID_rdval.
REQ-024 Latency one cycle: IFID_ready=1, no stall, no branch -> next edge all outputs updated, IDEX_ready=1.
REQ-025 IFID_ready=0 (no stall/branch) -> next edge IDEX_ready=0; other outputs don't-care.
REQ-026 EXID_stall=1 -> all registered outputs hold; IDIF_stall = EXID_stall combinationally.
REQ-027 Priority: reset > EXIF_branch > EXID_stall > IFID_ready; EXIF_branch=1 -> next edge IDEX_ready=0 and opcode 0.
REQ-028 Register file write occurs every edge with WBID_wen=1, including during stall/flush.

Reset
REQ-029 Reset: IDEX_ready 0, IDEX_npc/opcode/rs1/rs2/immediate 0, rd 0, IDEX_rs1reg/IDEX_rs2reg 6'h20, all 32 registers 0; IDIF_stall follows EXID_stall.
REQ-030 Reset asserted mid-stream discards the in-flight instruction; first valid output is one edge after first accepted instruction post-reset.

Structure
REQ-031 Package decode_pkg holds 7-bit major opcode constants, NO_REG = 6'h20, and mnemonic-to-64-bit ASCII constants.
REQ-032 One sub-module decode_regfile (32x64, two async read ports, one sync write port, x0 hardwired zero, bypass); decode logic combinational into one output register bank.

Verification
REQ-033 IFID_instreg=0xFFF00293, IFID_npc=0x1000, ready -> next cycle opcode "addi", rd 5, IDEX_rs1reg 0, rs1 0, immediate 20'hFFFFF, IDEX_rs2reg 6'h20, IDEX_npc 0x1000, IDEX_ready 1.
REQ-034 0x123450B7 -> "lui", rd 1, immediate 20'h12345, both src indices 6'h20.
REQ-035 0xFE208CE3 -> "beq", rd 0, IDEX_rs1reg 1, IDEX_rs2reg 2, immediate 20'hFFFF8.
REQ-036 WBID_wen=1, WBID_rd=5, WBID_rdval=0xDEAD with 0x00528333 -> "add", rd 6, rs1=rs2=0xDEAD; later read of x5 also 0xDEAD.
REQ-037 EXID_stall=1 for 3 cycles while new words arrive -> IDIF_stall=1 same cycles, outputs unchanged; EXIF_branch=1 -> next IDEX_ready=0, opcode 0.
